// File: rtl/div_iter_core_pkg.sv
// Shared types and constants for the iterative divider.
// Op encodings follow the M-extension funct3 low bits.
package div_iter_core_pkg;

    localparam int XLEN = 32;
    localparam int DIVW = 63;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/div_operand_prep.sv
// Operand conditioning for the divider: magnitudes,
// aligned divisor and the sign to apply to the result.
module div_operand_prep
    import div_iter_core_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] dividend,
    output logic [DIVW-1:0] divisor,
    output logic            outsign
);

    logic            sgn;
    logic [XLEN-1:0] b_abs;

    // Take magnitudes of signed operands and align the divisor
    always_comb begin
        sgn      = ~op[0];
        dividend = (sgn & rs1[31]) ? -rs1 : rs1;
        b_abs    = (sgn & rs2[31]) ? -rs2 : rs2;
        divisor  = {b_abs, 31'b0};
    end

    // Result sign: quotient follows operand signs, remainder follows dividend
    always_comb begin
        outsign = 1'b0;
        case (op)
            DIV:     outsign = (rs1[31] != rs2[31]) & (rs2 != '0);
            REM:     outsign = rs1[31];
            default: outsign = 1'b0;
        endcase
    end

endmodule

// File: rtl/div_iter_core.sv
// Iterative restoring divider: one quotient bit per clock,
// 33 edges from accepted start to the result strobe.
module div_iter_core
    import div_iter_core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd
);

    state_e          state_q,    state_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [DIVW-1:0] divisor_q,  divisor_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] msk_q,      msk_d;
    logic [5:0]      cnt_q,      cnt_d;
    logic            outsign_q,  outsign_d;
    logic            is_rem_q,   is_rem_d;
    logic [XLEN-1:0] rd_q,       rd_d;
    logic            rd_valid_q, rd_valid_d;

    logic [XLEN-1:0] prep_dividend;
    logic [DIVW-1:0] prep_divisor;
    logic            prep_outsign;

    div_operand_prep u_prep (
        .op       (op),
        .rs1      (rs1),
        .rs2      (rs2),
        .dividend (prep_dividend),
        .divisor  (prep_divisor),
        .outsign  (prep_outsign)
    );

    // Next-state: load in IDLE, one restoring step per RUN cycle, publish in DONE
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quotient_d = quotient_q;
        msk_d      = msk_q;
        cnt_d      = cnt_q;
        outsign_d  = outsign_q;
        is_rem_d   = is_rem_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = prep_dividend;
                    divisor_d  = prep_divisor;
                    quotient_d = '0;
                    msk_d      = 32'h8000_0000;
                    cnt_d      = '0;
                    outsign_d  = prep_outsign;
                    is_rem_d   = op[1];
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (divisor_q <= {31'b0, dividend_q}) begin
                    dividend_d = dividend_q - divisor_q[XLEN-1:0];
                    quotient_d = quotient_q | msk_q;
                end
                divisor_d = divisor_q >> 1;
                msk_d     = msk_q >> 1;
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (is_rem_q) begin
                    rd_d = outsign_q ? -dividend_q : dividend_q;
                end else begin
                    rd_d = outsign_q ? -quotient_q : quotient_q;
                end
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            quotient_q <= '0;
            msk_q      <= '0;
            cnt_q      <= '0;
            outsign_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quotient_q <= quotient_d;
            msk_q      <= msk_d;
            cnt_q      <= cnt_d;
            outsign_q  <= outsign_d;
            is_rem_q   <= is_rem_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Outputs
    always_comb begin
        busy     = (state_q != IDLE);
        rd_valid = rd_valid_q;
        rd       = rd_q;
    end

endmodule

// File: doc/div_iter_core.md
DIV_ITER_CORE -- requirements
Module: div_iter_core

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 rs1  input  32  dividend; sampled with start.
REQ-007 rs2  input  32  divisor; sampled with start.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 rd_valid  output reg  1  one-cycle result strobe.
REQ-010 rd  output reg  32  result; holds its value until the next rd_valid.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-012 IDLE with start=1 SHALL load the operands and go to RUN at that edge (E0); otherwise it stays in IDLE.
REQ-013 Load SHALL set the following registers:
- signed = ~op[0].
- dividend[31:0] = (signed & rs1[31]) ? -rs1 : rs1.
- divisor[62:0] = ((signed & rs2[31]) ? -rs2 : rs2) << 31.
- quotient = 0; msk = 32'h8000_0000; cnt = 0.
REQ-014 Load SHALL latch outsign:
- DIV: (rs1[31] != rs2[31]) & (rs2 != 0).
- REM: rs1[31].
- unsigned ops: 0.
REQ-015 Each RUN edge SHALL perform one restoring step:
- if divisor <= {31'b0, dividend}, subtract divisor from dividend and OR msk into quotient.
- then shift divisor and msk right by 1 and increment cnt.
REQ-016 RUN SHALL perform exactly 32 steps (E1..E32) and go to DONE at E32.
REQ-017 At E33, DONE SHALL write rd and set rd_valid=1, then go to IDLE:
- DIV/DIVU: rd = outsign ? -quotient : quotient.
- REM/REMU: rd = outsign ? -dividend : dividend.
REQ-018 rd_valid SHALL be high for exactly the one cycle after E33; latency is 33 clock edges from the start-sampling edge.
REQ-019 start while busy=1 SHALL be ignored; no queuing, and the operands in flight SHALL be unaffected.
REQ-020 start asserted in the rd_valid cycle SHALL be accepted, because the FSM is in IDLE then (back-to-back issue).
REQ-021 Divide by zero SHALL need no special path; the algorithm SHALL yield:
- DIVU/DIV x/0 = 32'hFFFF_FFFF.
- REMU/REM x/0 = x.
REQ-022 Overflow 0x8000_0000 / 0xFFFF_FFFF (DIV) SHALL yield 0x8000_0000; REM of the same operands SHALL yield 0.
REQ-023 All arithmetic SHALL be two's complement, modulo the register width, with no saturation.

Reset
REQ-024 On reset:
- state = IDLE.
- busy = 0, rd_valid = 0, rd = 0.
- dividend, divisor, quotient, msk, cnt, outsign all 0.
REQ-025 Reset asserted mid-operation SHALL abort immediately with no rd_valid pulse; the first start after deassertion SHALL behave as a fresh operation.

Structure
REQ-026 A shared package SHALL hold:
- op encodings: DIV, DIVU, REM, REMU.
- the state enum: IDLE, RUN, DONE.
- constants XLEN=32 and DIVW=63.
REQ-027 Operand conditioning (REQ-013 negation/shift and REQ-014 outsign) SHALL be one combinational sub-module, div_operand_prep; the iteration and FSM stay in div_iter_core.

Verification
REQ-028 DIVU 100/7:
- start at edge E0 -> rd=14, rd_valid exactly in the cycle after E33.
- busy high from E0 to E33.
REQ-029 Signed operations:
- DIV -100/7 -> 0xFFFF_FFF2.
- REM -100/7 -> 0xFFFF_FFFE.
- DIV 100/-7 -> 0xFFFF_FFF2.
- REM 100/-7 -> 2.
REQ-030 Divide by zero:
- DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5.
- DIV -5/0 -> 0xFFFF_FFFF; REM -5/0 -> 0xFFFF_FFFB.
REQ-031 Overflow:
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
- REM of the same operands -> 0.
REQ-032 Start while busy:
- start DIVU 9/2, then pulse start with DIVU 1/1 at E5.
- -> the second start is ignored, rd=4, single rd_valid.
REQ-033 Reset and back-to-back:
- reset at E10 -> busy=0 at once, no rd_valid.
- next start DIVU 9/3 -> rd=3.
- start REMU 9/4 in the rd_valid cycle -> accepted, rd=1 after 33 more edges.
